// File: rtl/ram_pkg.sv
// Shared definitions for the block-RAM write-side logic.
//   BLOCKSIZE : address MSB index (address width is BLOCKSIZE+1)
//   DWIDTH    : RAM data word width
//   DEPTH     : number of RAM words
//   state_e   : scheduler state encoding (clear sweep / normal service)
package ram_pkg;

    localparam int unsigned BLOCKSIZE = 10;
    localparam int unsigned DWIDTH    = 32;
    localparam int unsigned DEPTH     = 2 ** (BLOCKSIZE + 1);

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req   in  N   request vector
//   ptr   in  PW  highest-priority index for this cycle
//   gnt   out N   one-hot grant (zero when no request)
//   idx   out PW  index of the granted requester
//   valid out 1   a requester was selected
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int unsigned j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // Scan ptr, ptr+1, ... wrapping; first hit wins.
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ram_wr_scheduler.sv
// Round-robin scheduler for the single write port of the 16R1W block RAM,
// with a clear sweep that writes INIT_VAL to every address after reset or
// on clear_req.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   req        : per-requester write request, held until granted
//   req_addr   : packed request addresses, slice i belongs to requester i
//   req_data   : packed request data, slice i belongs to requester i
//   gnt        : combinational one-hot grant; accepted at the clock edge
//   clear_req  : restart the clear sweep (only honoured in normal service)
//   init_done  : memory holds valid cleared contents
//   w_addr_1, w_din_1, w_enb_1 : registered RAM write port
module ram_wr_scheduler
    import ram_pkg::*;
#(
    parameter int unsigned BLOCKSIZE = ram_pkg::BLOCKSIZE,
    parameter int unsigned DWIDTH    = ram_pkg::DWIDTH,
    parameter int unsigned NREQ      = 4,
    parameter bit          INIT_EN   = 1'b1,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*(BLOCKSIZE+1)-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0]       req_data,
    output logic [NREQ-1:0]              gnt,
    input  logic                         clear_req,
    output logic                         init_done,
    output logic [BLOCKSIZE:0]           w_addr_1,
    output logic [DWIDTH-1:0]            w_din_1,
    output logic                         w_enb_1
);

    localparam int unsigned AW = BLOCKSIZE + 1;
    localparam int unsigned PW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              init_done_q, init_done_d;
    logic [AW-1:0]     w_addr_q, w_addr_d;
    logic [DWIDTH-1:0] w_din_q, w_din_d;
    logic              w_enb_q, w_enb_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    logic            serve;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Grants only in normal service; clear_req pre-empts every requester.
    assign serve = (state_q == StRun) && !clear_req && !rst;
    assign gnt   = serve ? pick_gnt : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        w_addr_d    = w_addr_q;
        w_din_d     = w_din_q;
        w_enb_d     = 1'b0;
        unique case (state_q)
            StInit: begin
                w_enb_d  = 1'b1;
                w_addr_d = cnt_q;
                w_din_d  = INIT_VAL;
                cnt_d    = cnt_q + AW'(1);
                // Last address issued: counter wraps to 0 on its own.
                if (&cnt_q) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
                if (clear_req) begin
                    state_d     = StInit;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end else if (pick_valid) begin
                    w_enb_d  = 1'b1;
                    w_addr_d = req_addr[pick_idx*AW +: AW];
                    w_din_d  = req_data[pick_idx*DWIDTH +: DWIDTH];
                    ptr_d    = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_EN ? StInit : StRun;
            cnt_q       <= '0;
            ptr_q       <= '0;
            init_done_q <= !INIT_EN;
            w_addr_q    <= '0;
            w_din_q     <= '0;
            w_enb_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            w_addr_q    <= w_addr_d;
            w_din_q     <= w_din_d;
            w_enb_q     <= w_enb_d;
        end
    end

    assign init_done = init_done_q;
    assign w_addr_1  = w_addr_q;
    assign w_din_1   = w_din_q;
    assign w_enb_1   = w_enb_q;

endmodule

// File: tb/tb_ram_wr_scheduler.sv
// Directed self-checking bench for ram_wr_scheduler (default parameters,
// NREQ=4) with a behavioural RAM fed from the write port.
module tb_ram_wr_scheduler;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 32;
    localparam int unsigned NR    = 4;
    localparam int unsigned DEPTH = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     gnt;
    logic              clear_req = 1'b0;
    logic              init_done;
    logic [AW-1:0]     w_addr_1;
    logic [DW-1:0]     w_din_1;
    logic              w_enb_1;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:DEPTH-1];

    ram_wr_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .clear_req (clear_req),
        .init_done (init_done),
        .w_addr_1  (w_addr_1),
        .w_din_1   (w_din_1),
        .w_enb_1   (w_enb_1)
    );

    always #5 clk = ~clk;

    // Behavioural RAM honouring the write-port contract.
    always @(posedge clk) begin
        if (w_enb_1) mem[w_addr_1] <= w_din_1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep from address 0; gnt must stay zero, init_done rises on the last write.
    task automatic run_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check({tag, "_enb"}, 64'(w_enb_1), 64'd1);
            check({tag, "_addr"}, 64'(w_addr_1), 64'(i));
            check({tag, "_din"}, 64'(w_din_1), 64'd0);
            check({tag, "_done"}, 64'(init_done), (i == DEPTH - 1) ? 64'd1 : 64'd0);
            if (i != DEPTH - 1) check({tag, "_gnt"}, 64'(gnt), 64'd0);
        end
    endtask

    initial begin
        int sample [8];
        sample = '{0, 1, 5, 'h100, 'h3FF, 'h400, 'h7FE, 'h7FF};
        for (int a = 0; a < DEPTH; a++) mem[a] = '1;
        for (int i = 0; i < int'(NR); i++) set_slot(i, AW'('h10 + i), DW'('hA0 + i));

        // Reset state, all requesters asking.
        req = 4'b1111;
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_enb", 64'(w_enb_1), 64'd0);
        check("rst_addr", 64'(w_addr_1), 64'd0);
        check("rst_din", 64'(w_din_1), 64'd0);
        check("rst_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("pre_sweep_gnt", 64'(gnt), 64'd0);

        run_sweep("sweep1");
        // Sweep over, ptr=0, all requesting: requester 0 first.
        check("post_sweep_gnt", 64'(gnt), 64'b0001);
        req = '0;
        tick();
        check("idle_enb", 64'(w_enb_1), 64'd0);
        for (int s = 0; s < 8; s++) check("clear_mem", 64'(mem[sample[s]]), 64'd0);

        // Single request from requester 2.
        set_slot(2, 11'h005, 32'hDEADBEEF);
        req = 4'b0100;
        #1;
        check("single_gnt", 64'(gnt), 64'b0100);
        tick();
        req = '0;
        check("single_enb", 64'(w_enb_1), 64'd1);
        check("single_addr", 64'(w_addr_1), 64'h005);
        check("single_din", 64'(w_din_1), 64'hDEADBEEF);
        set_slot(2, 11'h012, 32'hA2);
        // ptr is now 3.
        req = 4'b1111;
        #1;
        check("ptr3_gnt", 64'(gnt), 64'b1000);
        tick();
        check("ram_5", 64'(mem[5]), 64'hDEADBEEF);
        check("ptr3_addr", 64'(w_addr_1), 64'h013);

        // Held 1111 from ptr=0: order 0,1,2,3,0,1,2,3, back to back.
        for (int k = 0; k < 8; k++) begin
            check("rr_gnt", 64'(gnt), 64'(1 << (k % 4)));
            tick();
            check("rr_enb", 64'(w_enb_1), 64'd1);
            check("rr_addr", 64'(w_addr_1), 64'('h10 + (k % 4)));
            check("rr_din", 64'(w_din_1), 64'('hA0 + (k % 4)));
        end
        req = '0;
        tick();
        check("hold_enb", 64'(w_enb_1), 64'd0);
        check("hold_addr", 64'(w_addr_1), 64'h013);
        check("hold_din", 64'(w_din_1), 64'hA3);

        // Move ptr to 2, then 1010: 3 first, then 1, ptr back at 2.
        req = 4'b0010;
        tick();
        req = 4'b1010;
        #1;
        check("sparse_gnt0", 64'(gnt), 64'b1000);
        tick();
        check("sparse_gnt1", 64'(gnt), 64'b0010);
        check("sparse_addr0", 64'(w_addr_1), 64'h013);
        tick();
        check("sparse_addr1", 64'(w_addr_1), 64'h011);
        req = 4'b0111;
        #1;
        check("sparse_ptr2", 64'(gnt), 64'b0100);

        // clear_req beats req[0]; sweep restarts, then req[0] served.
        req = 4'b0001;
        clear_req = 1'b1;
        #1;
        check("clear_gnt", 64'(gnt), 64'd0);
        tick();
        clear_req = 1'b0;
        check("clear_done", 64'(init_done), 64'd0);
        check("clear_enb", 64'(w_enb_1), 64'd0);
        check("clear_gnt_init", 64'(gnt), 64'd0);
        run_sweep("sweep2");
        check("after_clear_gnt", 64'(gnt), 64'b0001);
        tick();
        req = '0;
        check("after_clear_enb", 64'(w_enb_1), 64'd1);
        check("after_clear_addr", 64'(w_addr_1), 64'h010);

        // Async reset mid-sweep at address 0x100.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i <= 'h100; i++) tick();
        check("mid_addr", 64'(w_addr_1), 64'h100);
        #1;
        rst = 1'b1;
        #1;
        check("async_enb", 64'(w_enb_1), 64'd0);
        check("async_addr", 64'(w_addr_1), 64'd0);
        check("async_done", 64'(init_done), 64'd0);
        check("async_gnt", 64'(gnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("restart_enb", 64'(w_enb_1), 64'd1);
            check("restart_addr", 64'(w_addr_1), 64'(i));
            check("restart_done", 64'(init_done), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
